// File: rtl/busca_instrucao.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack memory handshake
// and hands the instruction to decode over valid/ready. Includes a fetch watchdog.
module busca_instrucao #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] novoPC,
    input  logic        pc_load,
    input  logic        halt,
    output logic [31:0] atualPC,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_data,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_count,
    output logic        fetch_err
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ENTREGA,
        EXEC,
        HALTED
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [31:0] wd;
    logic        wd_trip;

    assign mem_addr = atualPC;

    always_comb begin
        wd_trip    = (TIMEOUT != 0) && (wd == 32'(TIMEOUT - 1));
        next_state = state;
        case (state)
            IDLE:    if (!halt) next_state = FETCH;
            FETCH: begin
                if (mem_ack)      next_state = ENTREGA;
                else if (wd_trip) next_state = HALTED;
            end
            ENTREGA: if (instr_ready) next_state = EXEC;
            EXEC:    if (pc_load) next_state = halt ? IDLE : FETCH;
            HALTED:  next_state = HALTED;
            default: next_state = IDLE;
        endcase
    end

    // mem_req/instr_valid are registered copies of the decoded next state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            atualPC     <= RESET_PC;
            mem_req     <= 1'b0;
            instr       <= '0;
            instr_valid <= 1'b0;
            instr_count <= '0;
            fetch_err   <= 1'b0;
            wd          <= '0;
        end else begin
            state       <= next_state;
            mem_req     <= (next_state == FETCH);
            instr_valid <= (next_state == ENTREGA);

            if (state == FETCH && next_state == FETCH) wd <= wd + 32'd1;
            else                                       wd <= '0;

            if (state == FETCH && mem_ack) instr <= mem_data;
            if (state == FETCH && next_state == HALTED) fetch_err <= 1'b1;

            if (state == EXEC && pc_load) begin
                atualPC     <= novoPC;
                instr_count <= instr_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_busca_instrucao.sv
// Self-checking bench for busca_instrucao: directed scenarios plus randomized
// instruction transactions checked against a transaction-level PC/count model.
module tb_busca_instrucao;

    logic        clk = 1'b0;
    logic        rst_n, rst_n2;
    logic [31:0] novoPC;
    logic        pc_load, halt;
    logic        mem_ack, mem_ack2;
    logic [31:0] mem_data;
    logic        instr_ready;

    logic [31:0] atualPC, mem_addr, instr, instr_count;
    logic        mem_req, instr_valid, fetch_err;
    logic [31:0] atualPC2, mem_addr2, instr2, instr_count2;
    logic        mem_req2, instr_valid2, fetch_err2;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] exp_pc, exp_cnt;

    always #5 clk = ~clk;

    busca_instrucao #(.RESET_PC(32'h10), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .novoPC(novoPC), .pc_load(pc_load), .halt(halt),
        .atualPC(atualPC), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_data(mem_data), .instr(instr),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_count(instr_count), .fetch_err(fetch_err)
    );

    busca_instrucao #(.RESET_PC(32'h0), .TIMEOUT(4)) dut_wd (
        .clk(clk), .rst_n(rst_n2), .novoPC(novoPC), .pc_load(pc_load), .halt(halt),
        .atualPC(atualPC2), .mem_req(mem_req2), .mem_addr(mem_addr2),
        .mem_ack(mem_ack2), .mem_data(mem_data), .instr(instr2),
        .instr_valid(instr_valid2), .instr_ready(instr_ready),
        .instr_count(instr_count2), .fetch_err(fetch_err2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full instruction, entered in the first FETCH cycle. ad/rd/pd are the
    // cycles of delay before ack, ready and pc_load respectively.
    task automatic do_instr(input int ad, input int rd, input int pd,
                            input logic [31:0] data, input logic [31:0] npc,
                            input logic h, input logic spur);
        for (int i = 0; i < ad; i++) begin
            chk("fetch_req", {31'b0, mem_req}, 32'd1);
            chk("fetch_addr", mem_addr, exp_pc);
            chk("fetch_valid", {31'b0, instr_valid}, 32'd0);
            step();
        end
        chk("fetch_req", {31'b0, mem_req}, 32'd1);
        chk("fetch_addr", mem_addr, exp_pc);
        mem_ack  = 1'b1;
        mem_data = data;
        step();
        mem_ack  = 1'b0;
        mem_data = $urandom;
        halt     = h;
        for (int i = 0; i < rd; i++) begin
            chk("deliver_valid", {31'b0, instr_valid}, 32'd1);
            chk("deliver_instr", instr, data);
            chk("deliver_req", {31'b0, mem_req}, 32'd0);
            chk("deliver_pc", atualPC, exp_pc);
            if (spur) begin
                pc_load  = 1'b1;
                novoPC   = $urandom;
                mem_ack  = 1'b1;
                mem_data = $urandom;
            end
            step();
            pc_load = 1'b0;
            mem_ack = 1'b0;
        end
        chk("deliver_valid", {31'b0, instr_valid}, 32'd1);
        chk("deliver_instr", instr, data);
        chk("deliver_pc", atualPC, exp_pc);
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        for (int i = 0; i < pd; i++) begin
            chk("exec_valid", {31'b0, instr_valid}, 32'd0);
            chk("exec_req", {31'b0, mem_req}, 32'd0);
            chk("exec_pc", atualPC, exp_pc);
            if (spur) instr_ready = 1'b1;
            step();
            instr_ready = 1'b0;
        end
        chk("exec_valid", {31'b0, instr_valid}, 32'd0);
        pc_load = 1'b1;
        novoPC  = npc;
        step();
        pc_load = 1'b0;
        exp_pc  = npc;
        exp_cnt = exp_cnt + 32'd1;
        chk("load_pc", atualPC, exp_pc);
        chk("load_addr", mem_addr, exp_pc);
        chk("load_count", instr_count, exp_cnt);
        chk("load_req", {31'b0, mem_req}, {31'b0, ~h});
        chk("load_valid", {31'b0, instr_valid}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; rst_n2 = 1'b0;
        novoPC = '0; pc_load = 1'b0; halt = 1'b0;
        mem_ack = 1'b0; mem_ack2 = 1'b0; mem_data = '0; instr_ready = 1'b0;
        step();
        step();
        chk("rst_req", {31'b0, mem_req}, 32'd0);
        chk("rst_pc", atualPC, 32'h10);
        chk("rst_count", instr_count, 32'd0);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_err", {31'b0, fetch_err}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        rst_n = 1'b1;
        step();
        chk("first_req", {31'b0, mem_req}, 32'd1);
        chk("first_addr", mem_addr, 32'h10);
        exp_pc  = 32'h10;
        exp_cnt = 32'd0;

        do_instr(0, 0, 0, 32'h00500093, 32'h11, 1'b0, 1'b0);
        do_instr(5, 3, 1, $urandom, 32'h12, 1'b0, 1'b1);
        do_instr(1, 0, 2, $urandom, 32'h40, 1'b0, 1'b0);
        for (int n = 0; n < 25; n++)
            do_instr($urandom_range(0, 8), $urandom_range(0, 4), $urandom_range(0, 3),
                     $urandom, $urandom, 1'b0, 1'($urandom_range(0, 1)));

        // halt raised during delivery: instruction completes, then the FSM parks
        do_instr(1, 2, 1, $urandom, 32'h80, 1'b1, 1'b0);
        step();
        chk("halt_idle_req", {31'b0, mem_req}, 32'd0);
        chk("halt_idle_pc", atualPC, 32'h80);
        halt = 1'b0;
        step();
        chk("resume_req", {31'b0, mem_req}, 32'd1);
        chk("resume_addr", mem_addr, 32'h80);

        force dut.instr_count = 32'hFFFF_FFFF;
        step();
        release dut.instr_count;
        exp_cnt = 32'hFFFF_FFFF;
        do_instr(0, 0, 0, $urandom, 32'h81, 1'b0, 1'b0);
        chk("wrap_count", instr_count, 32'd0);

        // reset mid-fetch aborts and restores RESET_PC
        rst_n = 1'b0;
        step();
        chk("midrst_req", {31'b0, mem_req}, 32'd0);
        chk("midrst_pc", atualPC, 32'h10);
        chk("midrst_count", instr_count, 32'd0);

        // watchdog instance, TIMEOUT=4
        step();
        rst_n2 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("wd_req", {31'b0, mem_req2}, 32'd1);
            chk("wd_err_clear", {31'b0, fetch_err2}, 32'd0);
        end
        step();
        chk("wd_err_set", {31'b0, fetch_err2}, 32'd1);
        chk("wd_req_drop", {31'b0, mem_req2}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            mem_ack2 = 1'b1; pc_load = 1'b1; novoPC = $urandom; instr_ready = 1'b1;
            step();
            chk("wd_stuck_err", {31'b0, fetch_err2}, 32'd1);
            chk("wd_stuck_req", {31'b0, mem_req2}, 32'd0);
            chk("wd_stuck_valid", {31'b0, instr_valid2}, 32'd0);
            chk("wd_stuck_pc", atualPC2, 32'd0);
            chk("wd_stuck_count", instr_count2, 32'd0);
        end
        mem_ack2 = 1'b0; pc_load = 1'b0; instr_ready = 1'b0;
        rst_n2 = 1'b0;
        step();
        chk("wd_rst_err", {31'b0, fetch_err2}, 32'd0);
        chk("wd_rst_pc", atualPC2, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
